// File: rtl/wf_pc_table_pkg.sv
// Shared constants for the per-wavefront PC table: default geometry,
// fetch advance sizes and the instruction alignment mask.
package pc_table_pkg;

    localparam int DEF_NUM_WF   = 40;
    localparam int DEF_WF_ID_W  = 6;
    localparam int DEF_PC_WIDTH = 32;

    localparam int PC_INC_WORD  = 4;
    localparam int PC_INC_DWORD = 8;

    // Instructions are 4-byte aligned; users slice this to their PC width.
    localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/wf_pc_table_if.sv
// Request/response bundle between the fetch scheduler (master) and the
// PC table (slave).
interface wf_pc_table_if #(
    parameter int NUM_WF   = 40,
    parameter int WF_ID_W  = 6,
    parameter int PC_WIDTH = 32
);

    logic                init_en;
    logic [WF_ID_W-1:0]  init_wf_id;
    logic [PC_WIDTH-1:0] init_pc;
    logic                redirect_en;
    logic [WF_ID_W-1:0]  redirect_wf_id;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                retire_en;
    logic [WF_ID_W-1:0]  retire_wf_id;
    logic                fetch_en;
    logic [WF_ID_W-1:0]  fetch_wf_id;
    logic                fetch_dword;
    logic                fetch_vld;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                fetch_first;
    logic                fetch_err;
    logic [NUM_WF-1:0]   active_mask;

    modport master (
        output init_en, init_wf_id, init_pc,
        output redirect_en, redirect_wf_id, redirect_pc,
        output retire_en, retire_wf_id,
        output fetch_en, fetch_wf_id, fetch_dword,
        input  fetch_vld, fetch_pc, fetch_first, fetch_err, active_mask
    );

    modport slave (
        input  init_en, init_wf_id, init_pc,
        input  redirect_en, redirect_wf_id, redirect_pc,
        input  retire_en, retire_wf_id,
        input  fetch_en, fetch_wf_id, fetch_dword,
        output fetch_vld, fetch_pc, fetch_first, fetch_err, active_mask
    );

endinterface

// File: rtl/wf_pc_table_entry.sv
// One wavefront slot: valid/first/pc state with init > retire > redirect >
// fetch-advance priority.
module wf_pc_entry
    import pc_table_pkg::*;
#(
    parameter int PC_WIDTH = DEF_PC_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_stb,
    input  logic                retire_stb,
    input  logic                redirect_stb,
    input  logic                adv_stb,
    input  logic                adv_dword,
    input  logic [PC_WIDTH-1:0] init_pc,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                valid,
    output logic                first,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_ALIGN_MASK[PC_WIDTH-1:0];

    logic [PC_WIDTH-1:0] pc_inc;

    assign pc_inc = adv_dword ? PC_WIDTH'(PC_INC_DWORD) : PC_WIDTH'(PC_INC_WORD);

    // Redirect and advance only touch live slots; the advance wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            first <= 1'b0;
            pc    <= '0;
        end else if (init_stb) begin
            valid <= 1'b1;
            first <= 1'b1;
            pc    <= init_pc & ALIGN_MASK;
        end else if (retire_stb) begin
            valid <= 1'b0;
            first <= 1'b0;
        end else if (redirect_stb && valid) begin
            first <= 1'b1;
            pc    <= redirect_pc & ALIGN_MASK;
        end else if (adv_stb && valid) begin
            first <= 1'b0;
            pc    <= pc + pc_inc;
        end
    end

endmodule

// File: rtl/wf_pc_table.sv
// Per-wavefront PC table for the fetch stage: slot decode, read-before-write
// fetch mux and the registered response toward the instruction buffer.
module wf_pc_table
    import pc_table_pkg::*;
#(
    parameter int NUM_WF   = DEF_NUM_WF,
    parameter int WF_ID_W  = DEF_WF_ID_W,
    parameter int PC_WIDTH = DEF_PC_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    wf_pc_table_if.slave  bus
);

    logic [NUM_WF-1:0]   valid_vec;
    logic [NUM_WF-1:0]   first_vec;
    logic [PC_WIDTH-1:0] pc_arr [NUM_WF];

    for (genvar i = 0; i < NUM_WF; i++) begin : g_slot
        logic init_stb;
        logic retire_stb;
        logic redirect_stb;
        logic adv_stb;

        // Ids at or above NUM_WF never match any slot and are dropped here.
        assign init_stb     = bus.init_en     && (bus.init_wf_id     == WF_ID_W'(i));
        assign retire_stb   = bus.retire_en   && (bus.retire_wf_id   == WF_ID_W'(i));
        assign redirect_stb = bus.redirect_en && (bus.redirect_wf_id == WF_ID_W'(i));
        assign adv_stb      = bus.fetch_en    && (bus.fetch_wf_id    == WF_ID_W'(i));

        wf_pc_entry #(
            .PC_WIDTH (PC_WIDTH)
        ) u_entry (
            .clk          (clk),
            .rst          (rst),
            .init_stb     (init_stb),
            .retire_stb   (retire_stb),
            .redirect_stb (redirect_stb),
            .adv_stb      (adv_stb),
            .adv_dword    (bus.fetch_dword),
            .init_pc      (bus.init_pc),
            .redirect_pc  (bus.redirect_pc),
            .valid        (valid_vec[i]),
            .first        (first_vec[i]),
            .pc           (pc_arr[i])
        );
    end

    // Stage p0: read slot state as of the start of the cycle (no bypass).
    logic                hit_p0;
    logic                first_p0;
    logic [PC_WIDTH-1:0] pc_p0;

    always_comb begin
        hit_p0   = 1'b0;
        first_p0 = 1'b0;
        pc_p0    = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (bus.fetch_wf_id == WF_ID_W'(i) && valid_vec[i]) begin
                hit_p0   = 1'b1;
                first_p0 = first_vec[i];
                pc_p0    = pc_arr[i];
            end
        end
    end

    // Stage p1: registered response; pc/first hold while no fetch is issued.
    logic                vld_p1;
    logic                err_p1;
    logic                first_p1;
    logic [PC_WIDTH-1:0] pc_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            first_p1 <= 1'b0;
            pc_p1    <= '0;
        end else begin
            vld_p1 <= bus.fetch_en && hit_p0;
            err_p1 <= bus.fetch_en && !hit_p0;
            if (bus.fetch_en) begin
                first_p1 <= first_p0;
                pc_p1    <= pc_p0;
            end
        end
    end

    assign bus.fetch_vld   = vld_p1;
    assign bus.fetch_err   = err_p1;
    assign bus.fetch_first = first_p1;
    assign bus.fetch_pc    = pc_p1;
    assign bus.active_mask = valid_vec;

endmodule

// File: tb/tb_wf_pc_table.sv
// Bench for wf_pc_table: directed vector table, reset corner and randomized
// traffic against a slot-array reference model.
module tb_wf_pc_table;

    localparam int NUM_WF   = 40;
    localparam int WF_ID_W  = 6;
    localparam int PC_WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wf_pc_table_if #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W), .PC_WIDTH(PC_WIDTH)) bus ();

    wf_pc_table #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W), .PC_WIDTH(PC_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays of slot state plus expected outputs.
    bit          m_valid [NUM_WF];
    bit          m_first [NUM_WF];
    logic [31:0] m_pc    [NUM_WF];
    bit          m_ovld, m_oerr, m_ofirst;
    logic [31:0] m_opc;

    task automatic model_step(input bit r, input int ie, iid, input logic [31:0] ipc,
                              input int re, rid, input logic [31:0] rpc,
                              input int te, tid, fe, fid, dw);
        bit          nv [NUM_WF];
        bit          nf [NUM_WF];
        logic [31:0] np [NUM_WF];
        bool_hit: begin end
        if (r) begin
            for (int s = 0; s < NUM_WF; s++) begin
                m_valid[s] = 0; m_first[s] = 0; m_pc[s] = '0;
            end
            m_ovld = 0; m_oerr = 0; m_ofirst = 0; m_opc = '0;
            return;
        end
        if (fe != 0) begin
            if (fid < NUM_WF && m_valid[fid]) begin
                m_ovld = 1; m_oerr = 0; m_opc = m_pc[fid]; m_ofirst = m_first[fid];
            end else begin
                m_ovld = 0; m_oerr = 1; m_opc = '0; m_ofirst = 0;
            end
        end else begin
            m_ovld = 0; m_oerr = 0;
        end
        nv = m_valid; nf = m_first; np = m_pc;
        // Lowest priority first; later writes overwrite earlier ones.
        if (fe != 0 && fid < NUM_WF && m_valid[fid]) begin
            np[fid] = 32'(m_pc[fid] + (dw != 0 ? 8 : 4));
            nf[fid] = 0;
        end
        if (re != 0 && rid < NUM_WF && m_valid[rid]) begin
            np[rid] = {rpc[31:2], 2'b00};
            nf[rid] = 1;
        end
        if (te != 0 && tid < NUM_WF) begin
            nv[tid] = 0; nf[tid] = 0;
        end
        if (ie != 0 && iid < NUM_WF) begin
            nv[iid] = 1; nf[iid] = 1; np[iid] = {ipc[31:2], 2'b00};
        end
        m_valid = nv; m_first = nf; m_pc = np;
    endtask

    task automatic step(input bit r, input int ie, iid, input logic [31:0] ipc,
                        input int re, rid, input logic [31:0] rpc,
                        input int te, tid, fe, fid, dw);
        logic [NUM_WF-1:0] m_mask;
        rst                = r;
        bus.init_en        = (ie != 0);
        bus.init_wf_id     = WF_ID_W'(iid);
        bus.init_pc        = ipc;
        bus.redirect_en    = (re != 0);
        bus.redirect_wf_id = WF_ID_W'(rid);
        bus.redirect_pc    = rpc;
        bus.retire_en      = (te != 0);
        bus.retire_wf_id   = WF_ID_W'(tid);
        bus.fetch_en       = (fe != 0);
        bus.fetch_wf_id    = WF_ID_W'(fid);
        bus.fetch_dword    = (dw != 0);
        model_step(r, ie, iid, ipc, re, rid, rpc, te, tid, fe, fid, dw);
        @(posedge clk);
        #1;
        for (int s = 0; s < NUM_WF; s++) m_mask[s] = m_valid[s];
        chk("mdl_vld",   64'(bus.fetch_vld),   64'(m_ovld));
        chk("mdl_err",   64'(bus.fetch_err),   64'(m_oerr));
        chk("mdl_first", 64'(bus.fetch_first), 64'(m_ofirst));
        chk("mdl_pc",    64'(bus.fetch_pc),    64'(m_opc));
        chk("mdl_mask",  64'(bus.active_mask), 64'(m_mask));
    endtask

    typedef struct {
        int ie; int iid; logic [31:0] ipc;
        int re; int rid; logic [31:0] rpc;
        int te; int tid;
        int fe; int fid; int dw;
        int xv; logic [31:0] xpc; int xf; int xe;
        int mbit; int mval;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic int pick_id();
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 47));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ie iid ipc            re rid rpc           te tid fe fid dw  xv xpc            xf xe mbit mval
        tbl[0]  = '{1, 3,  32'h0000_0100, 0, 0,  32'h0,        0, 0,  0, 0,  0,  0, 32'h0,         0, 0, 3,  1};
        tbl[1]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 3,  0,  1, 32'h0000_0100, 1, 0, 3,  1};
        tbl[2]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 3,  0,  1, 32'h0000_0104, 0, 0, -1, 0};
        tbl[3]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 3,  0,  1, 32'h0000_0108, 0, 0, 3,  1};
        tbl[4]  = '{1, 5,  32'h0000_0200, 0, 0,  32'h0,        0, 0,  0, 0,  0,  0, 32'h0000_0108, 0, 0, 5,  1};
        tbl[5]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 5,  1,  1, 32'h0000_0200, 1, 0, -1, 0};
        tbl[6]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 5,  1,  1, 32'h0000_0208, 0, 0, -1, 0};
        tbl[7]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 7,  0,  0, 32'h0,         0, 1, 7,  0};
        tbl[8]  = '{1, 2,  32'h0000_02FC, 0, 0,  32'h0,        0, 0,  0, 0,  0,  0, 32'h0,         0, 0, -1, 0};
        tbl[9]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 2,  0,  1, 32'h0000_02FC, 1, 0, -1, 0};
        tbl[10] = '{0, 0,  32'h0,         1, 2,  32'h0000_0400, 0, 0,  1, 2,  0,  1, 32'h0000_0300, 0, 0, -1, 0};
        tbl[11] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 2,  0,  1, 32'h0000_0400, 1, 0, -1, 0};
        tbl[12] = '{1, 9,  32'h0000_0500, 0, 0,  32'h0,        1, 9,  0, 0,  0,  0, 32'h0000_0400, 1, 0, 9,  1};
        tbl[13] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 9,  0,  1, 32'h0000_0500, 1, 0, -1, 0};
        tbl[14] = '{0, 0,  32'h0,         0, 0,  32'h0,        1, 9,  0, 0,  0,  0, 32'h0000_0500, 1, 0, 9,  0};
        tbl[15] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 9,  0,  0, 32'h0,         0, 1, -1, 0};
        tbl[16] = '{1, 11, 32'hFFFF_FFFC, 0, 0,  32'h0,        0, 0,  0, 0,  0,  0, 32'h0,         0, 0, 11, 1};
        tbl[17] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 11, 0,  1, 32'hFFFF_FFFC, 1, 0, -1, 0};
        tbl[18] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 11, 0,  1, 32'h0000_0000, 0, 0, -1, 0};
        tbl[19] = '{1, 12, 32'h0000_0103, 0, 0,  32'h0,        0, 0,  0, 0,  0,  0, 32'h0,         0, 0, -1, 0};
        tbl[20] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 12, 0,  1, 32'h0000_0100, 1, 0, -1, 0};
        tbl[21] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1, 45, 0,  0, 32'h0,         0, 1, -1, 0};

        // Reset: two cycles, then every output must read zero.
        step(1, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0);
        chk("rst_vld",   64'(bus.fetch_vld),   64'd0);
        chk("rst_err",   64'(bus.fetch_err),   64'd0);
        chk("rst_pc",    64'(bus.fetch_pc),    64'd0);
        chk("rst_first", 64'(bus.fetch_first), 64'd0);
        chk("rst_mask",  64'(bus.active_mask), 64'd0);

        for (int k = 0; k < NVEC; k++) begin
            step(0, tbl[k].ie, tbl[k].iid, tbl[k].ipc, tbl[k].re, tbl[k].rid, tbl[k].rpc,
                 tbl[k].te, tbl[k].tid, tbl[k].fe, tbl[k].fid, tbl[k].dw);
            chk($sformatf("tbl%0d_vld", k),   64'(bus.fetch_vld),   64'(tbl[k].xv));
            chk($sformatf("tbl%0d_err", k),   64'(bus.fetch_err),   64'(tbl[k].xe));
            chk($sformatf("tbl%0d_first", k), 64'(bus.fetch_first), 64'(tbl[k].xf));
            chk($sformatf("tbl%0d_pc", k),    64'(bus.fetch_pc),    64'(tbl[k].xpc));
            if (tbl[k].mbit >= 0)
                chk($sformatf("tbl%0d_mask", k), 64'(bus.active_mask[tbl[k].mbit]), 64'(tbl[k].mval));
        end

        // Reset mid-operation swallows a same-cycle init and fetch.
        step(1, 1, 0, 32'h0000_0600, 0, 0, '0, 0, 0, 1, 3, 0);
        chk("mid_rst_mask",  64'(bus.active_mask), 64'd0);
        chk("mid_rst_vld",   64'(bus.fetch_vld),   64'd0);
        chk("mid_rst_err",   64'(bus.fetch_err),   64'd0);
        chk("mid_rst_pc",    64'(bus.fetch_pc),    64'd0);
        chk("mid_rst_first", 64'(bus.fetch_first), 64'd0);
        step(0, 0, 0, '0, 0, 0, '0, 0, 0, 1, 0, 0);
        chk("post_rst_err", 64'(bus.fetch_err), 64'd1);

        // Randomized traffic with biased ids so requests collide on a slot.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ipc;
            logic [31:0] rpc;
            ipc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rpc = $urandom;
            step(($urandom_range(0, 299) == 0),
                 int'($urandom_range(0, 3) == 0), pick_id(), ipc,
                 int'($urandom_range(0, 3) == 0), pick_id(), rpc,
                 int'($urandom_range(0, 7) == 0), pick_id(),
                 int'($urandom_range(0, 3) != 0), pick_id(), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wf_pc_table.md
Name: wf_pc_table

Overview:
- Parametrised per-wavefront program-counter table for the fetch stage.
- Holds one PC, one valid bit and one "first" flag per wavefront slot.
- Dispatch initialises a slot. Fetch reads a slot and auto-advances it by the instruction size (4 or 8 bytes). Branch resolution redirects a slot, and end-of-program retires it.
- Output is registered toward the instruction buffer.

Parameters:
- NUM_WF, 40, number of wavefront slots
- WF_ID_W, 6, width of wavefront id ports; must satisfy 2^WF_ID_W >= NUM_WF
- PC_WIDTH, 32, PC width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset
- init_en  in  1  initialise slot (new wavefront dispatched)
- init_wf_id  in  WF_ID_W  slot to initialise
- init_pc  in  PC_WIDTH  start PC
- redirect_en  in  1  branch/jump target write
- redirect_wf_id  in  WF_ID_W  slot to redirect
- redirect_pc  in  PC_WIDTH  target PC
- retire_en  in  1  wavefront finished; invalidate slot
- retire_wf_id  in  WF_ID_W  slot to retire
- fetch_en  in  1  read-and-advance request
- fetch_wf_id  in  WF_ID_W  slot to fetch
- fetch_dword  in  1  0: advance by 4; 1: advance by 8 (64-bit instruction)
- fetch_vld  out  1  registered: fetch_pc/fetch_first valid this cycle
- fetch_pc  out  PC_WIDTH  registered PC returned
- fetch_first  out  1  registered: first fetch after init or redirect
- fetch_err  out  1  registered: fetch hit an invalid or out-of-range slot
- active_mask  out  NUM_WF  valid bit of every slot, direct from state

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset clears every valid bit, first flag and PC to 0.
  - After reset, all outputs are 0 from the cycle after the reset edge.
  - Reset asserted mid-operation discards all same-cycle requests.
- Alignment: init_pc and redirect_pc are stored with bits [1:0] forced to 0.
- Per-slot update priority when several requests target the same slot in one cycle: init > retire > redirect > fetch-advance. Exactly one takes effect.
  - init: valid=1, first=1, pc=init_pc.
  - retire: valid=0, first=0; pc retained, don't-care.
  - redirect: applies only if valid=1; pc=redirect_pc, first=1. Redirect to an invalid slot is ignored.
  - fetch-advance: applies only if valid=1; pc=pc+4 or pc+8, modulo 2^PC_WIDTH (wraps silently); first=0.
  - Requests to different slots in the same cycle all take effect independently.
- Fetch read is read-before-write with 1-cycle latency:
  - Cycle N: fetch_en with slot S.
  - Cycle N+1: fetch_vld=1 and fetch_pc/fetch_first hold slot S's state as of the start of cycle N. Same-cycle init/redirect/retire on S is NOT bypassed.
  - Invalid or out-of-range slot: N+1 gives fetch_vld=0, fetch_err=1, fetch_pc=0, fetch_first=0, and no state change.
  - fetch_en=0: N+1 gives fetch_vld=0, fetch_err=0. fetch_pc and fetch_first hold their last value.
- Back-to-back fetches of the same slot in consecutive cycles see the advanced PC (pipelined at full rate).
- init/redirect/retire ids >= NUM_WF are ignored.
- active_mask updates on the same edge as the state.

Decomposition:
- Shared package pc_table_pkg holds:
  - PC increment constants (4, 8)
  - PC alignment mask
  - default NUM_WF, WF_ID_W, PC_WIDTH
- Sub-module wf_pc_entry, one instance per slot via generate:
  - Takes decoded per-slot init/retire/redirect/adv strobes plus shared data.
  - Holds the valid/first/pc flops and the priority next-state logic.
- Top level holds id decode, the read mux and the output register.

Test Plan:
- Reset then init slot 3 with 0x100, then fetch 3 (dword=0) three times back-to-back -> fetch_pc 0x100/0x104/0x108; fetch_first 1/0/0; active_mask bit 3 = 1.
- Fetch slot 5 with fetch_dword=1 after init 0x200 -> 0x200, then 0x208; a fetch of never-initialised slot 7 -> fetch_err=1, fetch_vld=0.
- Slot 2 at 0x300: same cycle redirect to 0x400 and fetch -> returns 0x300 with first=0; next fetch -> 0x400 with first=1.
- Same cycle init slot 9 to 0x500 and retire slot 9 -> slot 9 valid, pc 0x500. Retire alone -> mask bit clears and the next fetch gives fetch_err.
- Init 0xFFFFFFFC, fetch twice -> 0xFFFFFFFC then 0x00000000. init_pc 0x103 is stored as 0x100. Fetch of wf_id 45 -> fetch_err.
- Rst asserted in the same cycle as init of slot 0 and a fetch -> mask 0 and next-cycle outputs all 0.
